// File: rtl/dot_accum_pkg.sv
// Shared constants and types for the dot_accum streaming dot-product engine.
// Default widths match the 25x25 signed multiplier that feeds this block.
package dot_accum_pkg;

  localparam int PROD_W_DEF = 50;
  localparam int ACC_W_DEF  = 64;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/dot_accum_sat_add.sv
// Combinational saturating signed add of a product onto the accumulator.
// Overflow is detected from the two top bits of the one-bit-wider sum.
module sat_add
  import dot_accum_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] wide;

  assign acc_ext  = {acc[ACC_W-1], acc};
  assign prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
  assign wide     = acc_ext + prod_ext;
  assign ovf      = wide[ACC_W] ^ wide[ACC_W-1];

  // The extra top bit holds the true sign, so it picks which rail to clamp to.
  always_comb begin
    sum = wide[ACC_W-1:0];
    if (ovf) begin
      if (wide[ACC_W]) sum = {1'b1, {(ACC_W-1){1'b0}}};
      else             sum = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dot_accum.sv
// Streaming saturating dot-product accumulator with valid/ready on both sides.
// The result register is a single skid-free slot; in_ready follows its drain.
module dot_accum
  import dot_accum_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  state_e           state;
  state_e           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sat;
  logic             ovf;
  logic             acc_fire;
  logic             out_fire;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign acc_fire  = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign cnt_next  = (&cnt) ? cnt : cnt + CNT_W'(1);

  sat_add #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_sat_add (
    .acc (acc),
    .prod(in_prod),
    .sum (sum),
    .ovf (ovf)
  );

  // A new last beat refills the slot even while it drains, keeping FULL.
  always_comb begin
    state_next = state;
    if (acc_fire && in_last) state_next = FULL;
    else if (out_fire)       state_next = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_next;
      if (acc_fire) begin
        if (in_last) begin
          out_acc   <= sum;
          out_count <= cnt_next;
          out_sat   <= sat | ovf;
          acc       <= '0;
          cnt       <= '0;
          sat       <= 1'b0;
        end else begin
          acc <= sum;
          cnt <= cnt_next;
          sat <= sat | ovf;
        end
      end
    end
  end

endmodule

// File: doc/dot_accum.md
# dot_accum

Sequential consumer placed directly downstream of the 25×25 signed array multiplier `mult`. It accepts one signed 50-bit product per beat over a valid/ready handshake and accumulates the products of a vector into a saturating signed accumulator. On the beat marked `in_last`, it emits the finished dot-product result with its own valid/ready handshake. This turns the combinational multiplier into a streaming dot-product / FIR-tap engine.

## Interface
- `PROD_W`, default 50: product width; must equal 2×(multiplier operand width).
- `ACC_W`, default 64: accumulator and result width; must be ≥ `PROD_W`.
- `CNT_W`, default 8: beat-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_prod` and `in_last` are valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_prod`  in  `PROD_W`  signed product from `mult.prod`.
- `in_last`  in  1  this beat closes the current vector.
- `out_valid`  out  1  result registers hold a finished vector.
- `out_ready`  in  1  downstream takes the result this cycle.
- `out_acc`  out  `ACC_W`  signed saturated dot product.
- `out_count`  out  `CNT_W`  beats in the vector, saturating at 2^`CNT_W`−1.
- `out_sat`  out  1  saturation occurred at any beat of the vector.

## Operation
- Accept condition: `acc_fire = in_valid & in_ready`.
- Emit condition: `out_fire = out_valid & out_ready`.
- `in_ready = !out_valid | out_ready`. This is combinational and gives zero-bubble back-to-back vectors.
- Internal state:
  - `acc`: `ACC_W` bits, signed.
  - `cnt`: `CNT_W` bits.
  - `sat`: sticky flag.
  - Output registers `out_acc`, `out_count`, `out_sat`, `out_valid`.
- FSM, two states:
  - **ACCUM**: output register is empty or being drained.
  - **FULL**: result held, `out_valid` = 1.
- Per `acc_fire`:
  - `in_prod` is sign-extended to `ACC_W`+1 bits.
  - `sum = acc + in_prod`, computed in `ACC_W`+1 bits.
  - If `sum` exceeds the max positive `ACC_W` value, clamp to max positive. If it is below the min negative value, clamp to min negative. Either clamp sets `sat_next`.
  - `cnt_next = cnt+1`, saturating at all-ones.
- `acc_fire` with `in_last`=0:
  - `acc←sum_clamped`, `cnt←cnt_next`, `sat←sat|sat_next`.
- `acc_fire` with `in_last`=1:
  - `out_acc←sum_clamped`, `out_count←cnt_next`, `out_sat←sat|sat_next`, `out_valid←1`.
  - Internal `acc`, `cnt`, `sat` clear to 0, ready for the next vector.
- Transitions:
  - `out_fire` without a new last beat → `out_valid←0` (FULL→ACCUM).
  - `out_fire` together with an `in_last` accept → output registers load the new result and `out_valid` stays 1.
- No `acc_fire` → `acc`, `cnt`, `sat` hold.
- A single-beat vector (`in_last` on the first beat) gives `out_acc` = `in_prod` sign-extended and `out_count`=1.
- Output registers are stable while `out_valid` & !`out_ready`.
- Non-last beats are accepted while FULL only when `in_ready` is high.

## Timing
- Reset values: `out_valid`=0, `out_acc`=0, `out_count`=0, `out_sat`=0. Internal `acc`, `cnt`, `sat` are also 0.
- `in_ready` = 1 combinationally after reset.
- Latency: a last beat accepted at edge k gives `out_valid`=1 after edge k, i.e. 1 cycle.
- Throughput: one product per cycle while `out_ready` is held high.
- `rst` asserted mid-vector or with a pending result:
  - Partial sum and pending result are discarded immediately.
  - No result appears after reset is released.
- `in_valid` with `in_ready`=0 is a stall. The upstream must hold `in_prod` and `in_last` stable until accepted.

## Structure
- Shared package `dot_accum_pkg` holds:
  - The `PROD_W`/`ACC_W`/`CNT_W` default constants.
  - The two-state enum (ACCUM, FULL).
  - The signed min/max `ACC_W` limit constants.
- One sub-module, `sat_add`: a combinational signed adder of `ACC_W` + `PROD_W` operands. It outputs the clamped `ACC_W` sum and an overflow flag.
- All registers live in `dot_accum`.

## Test plan
- **Reset:** assert `rst` mid-stream → all outputs 0, `in_ready`=1. A vector sent after release gives only its own result.
- **Basic vector:** 3-beat vector with products 6, −20, 100 and `out_ready`=1 → `out_acc`=86, `out_count`=3, `out_sat`=0, `out_valid` for exactly one cycle.
- **Back-to-back vectors:**
  - Single-beat vector 5 immediately followed by a single-beat vector −7 → results 5 then −7 on consecutive cycles.
  - No bubble on `in_ready`.
- **Back-pressure:**
  - Hold `out_ready`=0 after a result → `in_ready`=0, result stable for 10 cycles.
  - Upstream stalls with data held.
  - Raising `out_ready` drains the result.
- **Saturation, `ACC_W`=50:**
  - Two beats of +2^48 → `out_acc`=2^49−1, `out_sat`=1.
  - Two beats of −2^49 → `out_acc`=−2^49, `out_sat`=1.
  - The next clean vector has `out_sat`=0.
- **Count saturation, `CNT_W`=4:** 20-beat vector of product 1 → `out_count`=15, `out_acc`=20.
